// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage with IF/ID pipeline register
module if_stage #(
  parameter int PC_LENGTH = 32,
  parameter int INST_LENGTH = 32,
  parameter logic [PC_LENGTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_LENGTH-1:0] inst,
  output logic                   romCe,
  output logic [PC_LENGTH-1:0]   pc,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [PC_LENGTH-1:0]   branch_target,
  input  logic                   flush,
  input  logic [PC_LENGTH-1:0]   flush_target,
  output logic                   id_valid,
  output logic [INST_LENGTH-1:0] id_inst,
  output logic [PC_LENGTH-1:0]   id_pc,
  output logic                   addr_err
);

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t state;

  // Redirect targets are word-aligned by dropping the low two bits.
  logic [PC_LENGTH-1:0] flush_aligned;
  logic [PC_LENGTH-1:0] branch_aligned;
  logic [PC_LENGTH-1:0] pc_next_seq;

  assign flush_aligned  = {flush_target[PC_LENGTH-1:2], 2'b00};
  assign branch_aligned = {branch_target[PC_LENGTH-1:2], 2'b00};
  assign pc_next_seq    = pc + PC_LENGTH'(4);

  // Fetch FSM, PC update and IF/ID register; priority rst > flush > stall > branch > sequential.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      romCe    <= 1'b0;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_inst  <= '0;
      id_pc    <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: begin
          // One idle cycle: enable the ROM, keep pc at the reset vector, load nothing.
          state <= FETCH;
          romCe <= 1'b1;
        end
        FETCH: begin
          romCe <= 1'b1;
          if (flush) begin
            pc       <= flush_aligned;
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_pc    <= '0;
            addr_err <= |flush_target[1:0];
          end else if (stall) begin
            // Everything holds; a pending branch must be re-presented after the stall.
          end else if (branch_en) begin
            // Delay slot: the instruction fetched this cycle still enters IF/ID.
            pc       <= branch_aligned;
            id_valid <= 1'b1;
            id_inst  <= inst;
            id_pc    <= pc;
            addr_err <= |branch_target[1:0];
          end else begin
            pc       <= pc_next_seq;
            id_valid <= 1'b1;
            id_inst  <= inst;
            id_pc    <= pc;
          end
        end
        default: begin
          state <= IDLE;
          romCe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard testbench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        romCe;
  logic [31:0] pc;
  logic        stall;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        addr_err;

  int total = 0;
  int bad = 0;

  logic [31:0] sb[$];
  logic [31:0] exp_pc;
  logic        exp_fetch;
  logic        exp_err;

  if_stage #(
    .PC_LENGTH(32),
    .INST_LENGTH(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inst(inst),
    .romCe(romCe),
    .pc(pc),
    .stall(stall),
    .branch_en(branch_en),
    .branch_target(branch_target),
    .flush(flush),
    .flush_target(flush_target),
    .id_valid(id_valid),
    .id_inst(id_inst),
    .id_pc(id_pc),
    .addr_err(addr_err)
  );

  // Combinational ROM: word content equals its address.
  assign inst = pc;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // One clock with the currently driven inputs; the model predicts pc/romCe/addr_err and
  // pushes the address of every instruction that should land in IF/ID.
  task automatic tick();
    logic        load;
    logic [31:0] nxt;
    logic        fetch_n;
    logic        err_n;
    logic [31:0] e;
    load = 1'b0;
    nxt = exp_pc;
    fetch_n = exp_fetch;
    err_n = 1'b0;
    if (rst) begin
      nxt = 32'h0;
      fetch_n = 1'b0;
    end else if (!exp_fetch) begin
      fetch_n = 1'b1;
    end else if (flush) begin
      nxt = flush_target & 32'hFFFF_FFFC;
      err_n = (flush_target[1:0] != 2'b00);
    end else if (stall) begin
      nxt = exp_pc;
    end else if (branch_en) begin
      nxt = branch_target & 32'hFFFF_FFFC;
      err_n = (branch_target[1:0] != 2'b00);
      load = 1'b1;
    end else begin
      nxt = exp_pc + 32'd4;
      load = 1'b1;
    end
    if (load) sb.push_back(exp_pc);
    @(posedge clk);
    #1;
    exp_pc = nxt;
    exp_fetch = fetch_n;
    exp_err = err_n;
    check("pc", pc, exp_pc);
    check("romCe", {31'b0, romCe}, {31'b0, exp_fetch});
    check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
    if (load) begin
      e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      check("sb_id_pc", id_pc, e);
      check("sb_id_inst", id_inst, e);
      check("sb_id_valid", {31'b0, id_valid}, 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    branch_en = 1'b0;
    branch_target = 32'h0;
    flush = 1'b0;
    flush_target = 32'h0;
    exp_pc = 32'h0;
    exp_fetch = 1'b0;
    exp_err = 1'b0;

    // Reset release
    for (int i = 0; i < 3; i++) tick();
    check("rst_romCe", {31'b0, romCe}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("rst_id_pc", id_pc, 32'h0);
    rst = 1'b0;
    tick();
    check("c1_romCe", {31'b0, romCe}, 32'd1);
    check("c1_pc", pc, 32'h0);
    check("c1_id_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check("c2_id_valid", {31'b0, id_valid}, 32'd1);
    check("c2_id_inst", id_inst, 32'h0);
    check("c2_id_pc", id_pc, 32'h0);
    check("c2_pc", pc, 32'h4);
    tick();
    check("c3_pc", pc, 32'h8);

    // Stall at pc = 0x10
    tick();
    tick();
    check("pre_stall_pc", pc, 32'h10);
    stall = 1'b1;
    branch_en = 1'b1;
    branch_target = 32'h300;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall_pc", pc, 32'h10);
      check("stall_id_pc", id_pc, 32'h0C);
    end
    stall = 1'b0;
    branch_en = 1'b0;
    tick();
    check("unstall_id_pc", id_pc, 32'h10);
    check("unstall_pc", pc, 32'h14);

    // Branch with delay slot at pc = 0x20
    for (int i = 0; i < 3; i++) tick();
    check("pre_br_pc", pc, 32'h20);
    branch_en = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_en = 1'b0;
    check("br_id_pc", id_pc, 32'h20);
    check("br_id_valid", {31'b0, id_valid}, 32'd1);
    check("br_pc", pc, 32'h100);
    tick();
    check("br_tgt_id_pc", id_pc, 32'h100);

    // Flush beats stall and branch at pc = 0x40
    branch_en = 1'b1;
    branch_target = 32'h40;
    tick();
    check("to40_pc", pc, 32'h40);
    flush = 1'b1;
    stall = 1'b1;
    branch_en = 1'b1;
    flush_target = 32'h180;
    branch_target = 32'h200;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    branch_en = 1'b0;
    check("fl_pc", pc, 32'h180);
    check("fl_id_valid", {31'b0, id_valid}, 32'd0);
    check("fl_id_inst", id_inst, 32'h0);
    check("fl_id_pc", id_pc, 32'h0);
    tick();

    // Misaligned branch target
    branch_en = 1'b1;
    branch_target = 32'h103;
    tick();
    branch_en = 1'b0;
    check("mis_pc", pc, 32'h100);
    check("mis_err", {31'b0, addr_err}, 32'd1);
    tick();
    check("mis_err_clr", {31'b0, addr_err}, 32'd0);

    // Misaligned flush target
    flush = 1'b1;
    flush_target = 32'h181;
    tick();
    flush = 1'b0;
    check("misf_pc", pc, 32'h180);
    check("misf_err", {31'b0, addr_err}, 32'd1);
    tick();
    check("misf_err_clr", {31'b0, addr_err}, 32'd0);

    // Wrap from 0xFFFF_FFFC
    branch_en = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    tick();
    branch_en = 1'b0;
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    tick();

    // Reset mid-stream at pc = 0x80
    branch_en = 1'b1;
    branch_target = 32'h80;
    tick();
    branch_en = 1'b0;
    check("mid_pc", pc, 32'h80);
    check("mid_id_valid", {31'b0, id_valid}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_romCe", {31'b0, romCe}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_id_valid", {31'b0, id_valid}, 32'd0);
    check("mid_rst_addr_err", {31'b0, addr_err}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("post_rst_pc", pc, 32'h8);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS core: the block directly upstream of the decode stage.
- Generates the fetch PC and `romCe` toward the instruction ROM, and samples the returned instruction.
- Holds the IF/ID pipeline register, with stall, branch redirect (delay slot honoured) and exception flush.
- The instruction ROM is combinational: `inst` is valid in the same cycle that `pc` and `romCe` are driven.

Parameters:
- PC_LENGTH, 32, width of program counter and all address ports
- INST_LENGTH, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- inst  input  INST_LENGTH  instruction word returned by the ROM for the current `pc`
- romCe  output  1  ROM chip enable
- pc  output  PC_LENGTH  current fetch address to the ROM
- stall  input  1  hold request from ID/EX hazard logic
- branch_en  input  1  redirect request from ID (resolved branch/jump)
- branch_target  input  PC_LENGTH  redirect address
- flush  input  1  exception/flush request
- flush_target  input  PC_LENGTH  exception vector
- id_valid  output  1  IF/ID register holds a real instruction
- id_inst  output  INST_LENGTH  IF/ID instruction
- id_pc  output  PC_LENGTH  IF/ID instruction address
- addr_err  output  1  one-cycle pulse: a misaligned redirect target was accepted

Behaviour:
- Reset values:
  - `romCe` = 0, `pc` = RESET_PC, `id_valid` = 0, `id_inst` = 0, `id_pc` = 0, `addr_err` = 0.
  - All other inputs are ignored while `rst` = 1.
- States:
  - IDLE: entered on reset. Next cycle goes to FETCH unconditionally; `romCe` <= 1, `pc` stays RESET_PC.
  - FETCH: steady state; `romCe` = 1. No other states.
- Reset mid-operation returns to IDLE on the next edge and discards everything in flight.
- Per-edge priority in FETCH: `rst` > `flush` > `stall` > `branch_en` > sequential.
- `flush` = 1:
  - `pc` <= `flush_target` with bits [1:0] forced to 0.
  - `id_valid` <= 0; `id_inst`/`id_pc` <= 0.
  - `flush` overrides `stall` and `branch_en` in the same cycle.
- `stall` = 1 (no flush):
  - `pc`, `id_valid`, `id_inst`, `id_pc` all hold; `romCe` stays 1.
  - `branch_en` is ignored; ID must hold the request until the stall drops.
- `branch_en` = 1 (no flush, no stall):
  - `pc` <= `branch_target` with [1:0] forced to 0.
  - IF/ID captures the instruction fetched this cycle (delay slot): `id_inst` <= `inst`, `id_pc` <= `pc`, `id_valid` <= 1.
- Sequential (none of the above): `id_inst` <= `inst`, `id_pc` <= `pc`, `id_valid` <= 1, `pc` <= `pc` + 4.
- Arithmetic: `pc` + 4 is modulo 2^PC_LENGTH, so 32'hFFFF_FFFC wraps to 0.
- In IDLE: `id_valid` = 0, and the IF/ID register does not load.
- `addr_err`:
  - Set to 1 for exactly one cycle after an accepted redirect (branch or flush) whose target[1:0] != 0; else 0.
  - Forced to 0 by reset.
- Latency:
  - Instruction at address A appears on `id_inst` one cycle after `pc` = A, when not stalled.
  - First valid `id_inst` (RESET_PC) appears 2 cycles after `rst` falls.
- `pc` always changes only on clock edges; no combinational path from any input to `pc` or `romCe`.

Test Plan:
- Reset release: `rst` high 3 cycles, then low; ROM returns word = address.
  - Cycle 1 after release: `romCe` = 1, `pc` = 0.
  - Cycle 2: `id_valid` = 1, `id_inst` = 0, `id_pc` = 0, `pc` = 4.
  - Cycle 3: `pc` = 8.
- Stall: at `pc` = 0x10, assert `stall` 2 cycles.
  - `pc` stays 0x10 and `id_pc` stays 0x0C for both cycles.
  - After release: `id_pc` = 0x10, `pc` = 0x14.
- Branch with delay slot: at `pc` = 0x20, `branch_en` = 1, `branch_target` = 0x100.
  - Next cycle: `id_pc` = 0x20, `id_valid` = 1, `pc` = 0x100.
  - Following cycle: `id_pc` = 0x100.
- Flush beats stall and branch: at `pc` = 0x40, `flush` = `stall` = `branch_en` = 1, `flush_target` = 0x180, `branch_target` = 0x200.
  - Next cycle: `pc` = 0x180, `id_valid` = 0, `id_inst` = 0.
- Misaligned target and wrap:
  - `branch_target` = 0x103: `pc` becomes 0x100 and `addr_err` pulses for exactly 1 cycle.
  - Separately, sequential fetch from 0xFFFF_FFFC: next `pc` = 0x0.
- Reset mid-stream: `rst` asserted while `pc` = 0x80 and `id_valid` = 1.
  - Next cycle: `romCe` = 0, `pc` = 0, `id_valid` = 0, `addr_err` = 0.
